ahb_ram_slave: RTL and testbench
================================

Name: ahb_ram_slave

Overview:
AHB-Lite responder for the data RAM region (haddr[31:24] = 8'hB0) and the counterpart of the core's master glue. It accepts pipelined address phases, applies programmable wait states, performs byte/half/word writes with byte-lane enables, and returns full read words. Illegal accesses get the two-cycle AHB ERROR response. It sits behind the address decoder, which drives hsel.

Parameters:
MEM_WORDS, 1024, depth of the 32-bit word array; the region offset limit is MEM_WORDS*4 bytes.
WAIT_STATES, 0, extra hreadyout=0 cycles inserted in every OKAY data phase (0..15).

Ports:
hclk  in  1  bus clock; all state updates on the rising edge.
hresetn  in  1  asynchronous, active-low reset.
hsel  in  1  slave select from the decoder.
haddr  in  32  address-phase address.
htrans  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
hwrite  in  1  1 = write.
hsize  in  3  000 byte, 001 half, 010 word.
hprot  in  4  protection; bit0 = data access.
hwdata  in  32  write data, valid during the data phase.
hready  in  1  bus-level ready (combined hreadyout of the active slave).
hreadyout  out  1  this slave's ready.
hresp  out  1  0 OKAY, 1 ERROR.
hrdata  out  32  read data.

Behaviour:
- Reset: state=IDLE, hreadyout=1, hresp=0, hrdata=0, wait counter=0, captured address-phase registers cleared. Memory contents are not reset. An asynchronous reset mid-transfer aborts the transfer and discards any pending write.
- Accept condition: hsel & hready & htrans[1]. On acceptance, register haddr, hsize, hwrite.
- With hsel & hready and IDLE/BUSY on htrans: no transfer; next cycle hreadyout=1, hresp=0.
- An accepted transfer is an error if any of these holds:
  - hsize > 010.
  - hsize=001 and haddr[0]=1.
  - hsize=010 and haddr[1:0]≠00.
  - haddr[31:24]≠8'hB0.
  - haddr[23:0] ≥ MEM_WORDS*4.
  - hwrite=1 and hprot[0]=0.
- States:
  - IDLE: hreadyout=1, hresp=0.
  - DATA: hreadyout=(wcnt==0), hresp=0. On entry wcnt=WAIT_STATES; it decrements each cycle while nonzero.
  - ERR1: hreadyout=0, hresp=1; always moves to ERR2.
  - ERR2: hreadyout=1, hresp=1.
- Transitions out of IDLE, DATA-with-wcnt==0, and ERR2 (each an hready=1 cycle):
  - accepted legal transfer → DATA;
  - accepted illegal transfer → ERR1;
  - otherwise → IDLE.
- Address pipelining: a new address phase is accepted in the same cycle that the previous data phase completes (zero bubble). Address phases presented while hreadyout=0 are ignored.
- Write: commits on the clock edge that ends the DATA cycle with wcnt==0, using hwdata sampled at that edge. Byte enables are derived from the captured haddr[1:0] and hsize:
  - byte: lane = addr[1:0];
  - half: lanes 0-1 or 2-3 by addr[1];
  - word: all lanes.
  - Data is taken from the matching hwdata lanes; other bytes are unchanged.
- Read: hrdata = full word at the captured word index, driven only in the DATA cycle with wcnt==0; 0 otherwise. The master performs lane extraction and sign extension.
- Write followed by a read of the same word in the next address phase: the read returns the newly written bytes.
- An ERROR transfer never modifies memory. hrdata=0 during ERR1 and ERR2.
- A transfer accepted in ERR2 (master did not cancel) is processed normally.

Decomposition:
- Package ahb_pkg holds:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ;
  - HSIZE_BYTE/HALF/WORD;
  - HRESP_OKAY/ERROR;
  - REGION_ROM=8'hA0, REGION_RAM=8'hB0;
  - the state enum {ST_IDLE, ST_DATA, ST_ERR1, ST_ERR2}.
- Sub-module ahb_byte_ram: MEM_WORDS×32 array with a 4-bit byte-write enable and an asynchronous read port. Kept separate so it can be swapped for an SRAM macro.

Test Plan:
- WAIT_STATES=0, word write 0xB0000010 data 0xDEADBEEF, then word read of the same address → hreadyout stays 1; read data phase returns hrdata=0xDEADBEEF, hresp=0.
- Byte write 0xAA to 0xB0000012 over a word 0x11223344, then word read → hrdata=0x11AA3344.
- WAIT_STATES=2, half read at 0xB0000002 → data phase shows hreadyout 0,0,1; hrdata is valid only in the third cycle.
- Misaligned word read at 0xB0000001 → ERR1 (hreadyout=0, hresp=1), then ERR2 (hreadyout=1, hresp=1); memory unchanged; hrdata=0.
- Back-to-back NONSEQ write 0xB0000000 (0x12345678) and read 0xB0000000 with no idle cycle → read returns 0x12345678, zero bubbles.
- hresetn pulsed low during the DATA cycle of a write with WAIT_STATES=3 → outputs return to reset values immediately; the targeted word keeps its prior contents.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, region codes and responder state type for the
// data-RAM responder.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [7:0] REGION_ROM = 8'hA0;
  localparam logic [7:0] REGION_RAM = 8'hB0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } ahb_state_e;

  // Byte-lane enables for an aligned access of the given size at offset lo.
  function automatic logic [3:0] byte_enables(input logic [1:0] lo, input logic [1:0] size);
    case (size)
      2'b00:   byte_enables = 4'b0001 << lo;
      2'b01:   byte_enables = lo[1] ? 4'b1100 : 4'b0011;
      default: byte_enables = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/ahb_byte_ram.sv
// MEM_WORDS x 32 storage with per-byte write enables and asynchronous read;
// kept standalone so it can be replaced by an SRAM macro wrapper.
module ahb_byte_ram #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned AW        = 10
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [MEM_WORDS];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ahb_ram_slave.sv
// AHB-Lite responder for the data RAM region: pipelined address capture,
// programmable wait states, byte-lane writes and two-cycle ERROR response.
module ahb_ram_slave
  import ahb_pkg::*;
#(
  parameter int unsigned MEM_WORDS   = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [3:0]  hprot,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic        hreadyout,
  output logic        hresp,
  output logic [31:0] hrdata
);

  localparam int unsigned AW    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int unsigned WCW   = 4;
  localparam logic [31:0] LIMIT = 32'(MEM_WORDS * 4);

  ahb_state_e     state_q, state_d;
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic [AW-1:0]  idx_q;
  logic [1:0]     lo_q;
  logic [1:0]     size_q;
  logic           write_q;

  logic        accept;
  logic        legal;
  logic        done;
  logic        last_beat;
  logic [3:0]  we;
  logic [31:0] rdata;
  logic        unused_bits;

  assign unused_bits = ^{hprot[3:1], htrans[0]};

  assign accept    = hsel & hready & htrans[1];
  assign last_beat = (state_q == ST_DATA) && (wcnt_q == '0);
  assign done      = (state_q == ST_IDLE) || (state_q == ST_ERR2) || last_beat;

  // Legality of the address phase currently on the bus.
  always_comb begin
    legal = 1'b1;
    if (hsize > HSIZE_WORD)                            legal = 1'b0;
    if ((hsize == HSIZE_HALF) && haddr[0])             legal = 1'b0;
    if ((hsize == HSIZE_WORD) && (haddr[1:0] != 2'b00)) legal = 1'b0;
    if (haddr[31:24] != REGION_RAM)                    legal = 1'b0;
    if ({8'h00, haddr[23:0]} >= LIMIT)                 legal = 1'b0;
    if (hwrite && !hprot[0])                           legal = 1'b0;
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
      idx_q   <= '0;
      lo_q    <= '0;
      size_q  <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      if (done && accept) begin
        idx_q   <= haddr[AW+1:2];
        lo_q    <= haddr[1:0];
        size_q  <= hsize[1:0];
        write_q <= hwrite;
      end
    end
  end

  // Next state, wait counter and bus response decode.
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    hreadyout = 1'b1;
    hresp     = HRESP_OKAY;
    hrdata    = '0;
    we        = '0;
    case (state_q)
      ST_DATA: begin
        hreadyout = (wcnt_q == '0);
        if (wcnt_q != '0) wcnt_d = wcnt_q - WCW'(1);
        if (last_beat && write_q)  we     = byte_enables(lo_q, size_q);
        if (last_beat && !write_q) hrdata = rdata;
      end
      ST_ERR1: begin
        hreadyout = 1'b0;
        hresp     = HRESP_ERROR;
        state_d   = ST_ERR2;
      end
      ST_ERR2: hresp = HRESP_ERROR;
      default: ;
    endcase
    if (done) begin
      if (accept && legal) begin
        state_d = ST_DATA;
        wcnt_d  = WCW'(WAIT_STATES);
      end else if (accept) begin
        state_d = ST_ERR1;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  ahb_byte_ram #(
    .MEM_WORDS(MEM_WORDS),
    .AW       (AW)
  ) u_ram (
    .clk  (hclk),
    .we   (we),
    .addr (idx_q),
    .wdata(hwdata),
    .rdata(rdata)
  );

endmodule

// File: tb/tb_ahb_ram_slave.sv
// Randomized bench for ahb_ram_slave at three wait-state settings, checked
// against a word-array memory model and per-beat expected bus responses.
module tb_ahb_ram_slave;
  import ahb_pkg::*;

  localparam int unsigned MW = 64;
  localparam int NI = 3;

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [3:0]  prot;
    logic [31:0] wdata;
  } xfer_t;

  logic        hclk;
  logic        hresetn   [NI];
  logic        hsel      [NI];
  logic [31:0] haddr     [NI];
  logic [1:0]  htrans    [NI];
  logic        hwrite    [NI];
  logic [2:0]  hsize     [NI];
  logic [3:0]  hprot     [NI];
  logic [31:0] hwdata    [NI];
  logic        hready    [NI];
  logic        hreadyout [NI];
  logic        hresp     [NI];
  logic [31:0] hrdata    [NI];

  logic [31:0] model [NI][MW];
  xfer_t       q[$];
  int          checks   = 0;
  int          failures = 0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    assign hready[g] = hreadyout[g];
    ahb_ram_slave #(
      .MEM_WORDS  (MW),
      .WAIT_STATES((g == 0) ? 0 : ((g == 1) ? 2 : 3))
    ) u_dut (
      .hclk     (hclk),
      .hresetn  (hresetn[g]),
      .hsel     (hsel[g]),
      .haddr    (haddr[g]),
      .htrans   (htrans[g]),
      .hwrite   (hwrite[g]),
      .hsize    (hsize[g]),
      .hprot    (hprot[g]),
      .hwdata   (hwdata[g]),
      .hready   (hready[g]),
      .hreadyout(hreadyout[g]),
      .hresp    (hresp[g]),
      .hrdata   (hrdata[g])
    );
  end

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 2 : 3);
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic xfer_t mk(input logic wr, input logic [31:0] addr,
                               input logic [2:0] size, input logic [31:0] wdata);
    xfer_t x;
    x.sel = 1'b1; x.trans = HTRANS_NONSEQ; x.addr = addr; x.wr = wr;
    x.size = size; x.prot = 4'h1; x.wdata = wdata;
    return x;
  endfunction

  function automatic bit is_legal(input xfer_t x);
    if (x.size > 3'd2) return 1'b0;
    if (x.size == 3'd1 && x.addr[0]) return 1'b0;
    if (x.size == 3'd2 && x.addr[1:0] != 2'b00) return 1'b0;
    if (x.addr[31:24] != 8'hB0) return 1'b0;
    if ({8'h00, x.addr[23:0]} >= 32'(MW * 4)) return 1'b0;
    if (x.wr && !x.prot[0]) return 1'b0;
    return 1'b1;
  endfunction

  // Bytes [off, off+size) of the word take the write data; others keep their value.
  function automatic void model_write(input int d, input xfer_t x);
    int idx = int'(x.addr[23:2]);
    int off = int'(x.addr[1:0]);
    int nb  = 1 << int'(x.size);
    for (int b = 0; b < 4; b++)
      if (b >= off && b < off + nb) model[d][idx][8*b +: 8] = x.wdata[8*b +: 8];
  endfunction

  function automatic xfer_t rand_xfer();
    xfer_t x;
    int r = $urandom_range(0, 99);
    x.sel   = 1'b1;
    x.trans = ($urandom_range(0, 1) == 1) ? HTRANS_SEQ : HTRANS_NONSEQ;
    x.wr    = 1'($urandom_range(0, 1));
    x.size  = 3'($urandom_range(0, 2));
    x.prot  = {3'($urandom), 1'b1};
    x.wdata = $urandom;
    x.addr  = 32'hB000_0000 | 32'($urandom_range(0, MW * 4 - 1));
    if (r >= 6) x.addr = x.addr & ~32'((1 << int'(x.size)) - 1);
    if (r >= 6 && r < 10)  x.addr = 32'hB000_0000 + 32'(MW * 4) + 32'($urandom_range(0, 64) * 4);
    if (r >= 10 && r < 13) x.addr = {REGION_ROM, x.addr[23:0]};
    if (r >= 13 && r < 16) x.size = 3'($urandom_range(3, 7));
    if (r >= 16 && r < 20) x.prot[0] = 1'b0;
    if (r >= 20 && r < 30) begin
      x.sel   = 1'($urandom_range(0, 1));
      x.trans = x.sel ? 2'($urandom_range(0, 1)) : HTRANS_NONSEQ;
    end
    return x;
  endfunction

  // Pipelined master: drains q on instance d, checking every data-phase beat.
  task automatic run(input int d);
    xfer_t ap, dp;
    bit    have_ap, have_dp = 1'b0, dp_ok = 1'b0;
    logic  rdy_seen, exp_rdy, exp_resp;
    logic [31:0] exp_rd;
    int    k = 0;
    int    ws = ws_of(d);
    int    budget = 20 + q.size() * (ws + 4);
    while ((q.size() > 0 || have_dp) && budget > 0) begin
      budget--;
      have_ap = (q.size() > 0);
      if (have_ap) begin
        ap = q[0];
        hsel[d] = ap.sel; htrans[d] = ap.trans; haddr[d] = ap.addr;
        hwrite[d] = ap.wr; hsize[d] = ap.size; hprot[d] = ap.prot;
      end else begin
        hsel[d] = 1'b0; htrans[d] = HTRANS_IDLE; haddr[d] = '0;
        hwrite[d] = 1'b0; hsize[d] = '0; hprot[d] = '0;
      end
      hwdata[d] = (have_dp && dp.wr) ? dp.wdata : $urandom;
      @(negedge hclk);
      exp_rdy = 1'b1; exp_resp = 1'b0; exp_rd = '0;
      if (have_dp && dp_ok) begin
        exp_rdy = (k == ws);
        if (k == ws && !dp.wr) exp_rd = model[d][int'(dp.addr[23:2])];
      end else if (have_dp) begin
        exp_rdy = (k == 1); exp_resp = 1'b1;
      end
      check_val($sformatf("hreadyout[%0d]", d), 32'(hreadyout[d]), 32'(exp_rdy));
      check_val($sformatf("hresp[%0d]", d), 32'(hresp[d]), 32'(exp_resp));
      check_val($sformatf("hrdata[%0d]", d), hrdata[d], exp_rd);
      rdy_seen = hreadyout[d];
      @(posedge hclk);
      if (rdy_seen) begin
        if (have_dp && dp_ok && dp.wr) model_write(d, dp);
        have_dp = 1'b0;
        if (have_ap) begin
          void'(q.pop_front());
          if (ap.sel && ap.trans[1]) begin
            have_dp = 1'b1; dp = ap; dp_ok = is_legal(ap); k = 0;
          end
        end
      end else begin
        k++;
      end
      #1;
    end
    check_val($sformatf("drained[%0d]", d), 32'(q.size() + int'(have_dp)), 32'd0);
    q.delete();
    hsel[d] = 1'b0; htrans[d] = HTRANS_IDLE;
  endtask

  initial begin
    for (int d = 0; d < NI; d++) begin
      hresetn[d] = 1'b0; hsel[d] = 1'b0; htrans[d] = HTRANS_IDLE; haddr[d] = '0;
      hwrite[d] = 1'b0; hsize[d] = '0; hprot[d] = '0; hwdata[d] = '0;
    end
    repeat (3) @(posedge hclk);
    @(negedge hclk);
    for (int d = 0; d < NI; d++) begin
      check_val($sformatf("rst_rdy[%0d]", d), 32'(hreadyout[d]), 32'd1);
      check_val($sformatf("rst_resp[%0d]", d), 32'(hresp[d]), 32'd0);
      check_val($sformatf("rst_rdata[%0d]", d), hrdata[d], 32'd0);
      hresetn[d] = 1'b1;
    end
    @(posedge hclk); #1;

    // Known contents everywhere before any read is compared.
    for (int d = 0; d < NI; d++) begin
      for (int i = 0; i < int'(MW); i++)
        q.push_back(mk(1'b1, 32'hB000_0000 + 32'(i * 4), HSIZE_WORD, $urandom));
      run(d);
    end

    q.push_back(mk(1'b1, 32'hB000_0010, HSIZE_WORD, 32'hDEAD_BEEF));
    q.push_back(mk(1'b0, 32'hB000_0010, HSIZE_WORD, 32'h0));
    q.push_back(mk(1'b1, 32'hB000_0010, HSIZE_WORD, 32'h1122_3344));
    q.push_back(mk(1'b1, 32'hB000_0012, HSIZE_BYTE, 32'hAAAA_AAAA));
    q.push_back(mk(1'b0, 32'hB000_0010, HSIZE_WORD, 32'h0));
    q.push_back(mk(1'b0, 32'hB000_0001, HSIZE_WORD, 32'h0));
    q.push_back(mk(1'b1, 32'hB000_0011, HSIZE_HALF, 32'hFFFF_FFFF));
    q.push_back(mk(1'b0, 32'hB000_0010, HSIZE_WORD, 32'h0));
    q.push_back(mk(1'b1, 32'hB000_0000, HSIZE_WORD, 32'h1234_5678));
    q.push_back(mk(1'b0, 32'hB000_0000, HSIZE_WORD, 32'h0));
    q.push_back(mk(1'b0, 32'hB000_0000 + 32'(MW * 4 - 4), HSIZE_WORD, 32'h0));
    q.push_back(mk(1'b0, 32'hB000_0000 + 32'(MW * 4), HSIZE_WORD, 32'h0));
    run(0);

    q.push_back(mk(1'b0, 32'hB000_0002, HSIZE_HALF, 32'h0));
    q.push_back(mk(1'b1, 32'hB000_0006, HSIZE_HALF, 32'hBEEF_CAFE));
    q.push_back(mk(1'b0, 32'hB000_0004, HSIZE_WORD, 32'h0));
    run(1);

    for (int d = 0; d < NI; d++) begin
      repeat (150) q.push_back(rand_xfer());
      run(d);
    end

    // Reset in the middle of a wait-stated write must drop the write.
    hsel[2] = 1'b1; htrans[2] = HTRANS_NONSEQ; haddr[2] = 32'hB000_0020;
    hwrite[2] = 1'b1; hsize[2] = HSIZE_WORD; hprot[2] = 4'h1;
    @(posedge hclk); #1;
    hsel[2] = 1'b0; htrans[2] = HTRANS_IDLE; hwdata[2] = 32'hCAFE_F00D;
    @(negedge hclk);
    check_val("rstmid_pre_rdy", 32'(hreadyout[2]), 32'd0);
    #2 hresetn[2] = 1'b0;
    #1;
    check_val("rstmid_rdy", 32'(hreadyout[2]), 32'd1);
    check_val("rstmid_resp", 32'(hresp[2]), 32'd0);
    check_val("rstmid_rdata", hrdata[2], 32'd0);
    @(negedge hclk);
    hresetn[2] = 1'b1;
    @(posedge hclk); #1;
    q.push_back(mk(1'b0, 32'hB000_0020, HSIZE_WORD, 32'h0));
    run(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
